// File: rtl/t03_dpu_pkg.sv
// Shared offsets, enums and address helpers for the DPU MMIO register bank.
package t03_dpu_pkg;

    localparam int unsigned OFF_GAME       = 0;
    localparam int unsigned OFF_PSTAT_BASE = 1;
    localparam int unsigned OFF_PPOS_BASE  = 2;
    localparam int unsigned PLAYER_STRIDE  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        P1WIN = 2'd2,
        P2WIN = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        STAND  = 2'd0,
        MOVE   = 2'd1,
        ATTACK = 2'd2,
        HIT    = 2'd3
    } player_state_t;

    // Word offset of player p's status register.
    function automatic logic [31:0] stat_off(input int unsigned p);
        return 32'(OFF_PSTAT_BASE + PLAYER_STRIDE * p);
    endfunction

    // Word offset of player p's position register.
    function automatic logic [31:0] pos_off(input int unsigned p);
        return 32'(OFF_PPOS_BASE + PLAYER_STRIDE * p);
    endfunction

endpackage

// File: rtl/t03_dpu_player_regs.sv
// One player's shadow/active state, health and position with readback words.
// Health clamping to MAX_HEALTH is enabled by defining T03_DPU_HEALTH_CLAMP_EN.
module t03_dpu_player_regs
    import t03_dpu_pkg::*;
#(
    parameter int unsigned COORD_W    = 11,
    parameter int unsigned HEALTH_W   = 5,
    parameter int unsigned MAX_HEALTH = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stat_we,
    input  logic                pos_we,
    input  logic [31:0]         wdata,
    input  logic                commit_en,
    output logic [1:0]          state,
    output logic [HEALTH_W-1:0] health,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic [31:0]         stat_word_c,
    output logic [31:0]         pos_word_c
);

    player_state_t         shd_state, act_state;
    logic [HEALTH_W-1:0]   shd_health, act_health, health_in;
    logic [COORD_W-1:0]    shd_x, shd_y, act_x, act_y;
    logic                  unused_wdata;
    logic                  unused_max;

    assign unused_wdata = ^wdata;
    assign unused_max   = ^32'(MAX_HEALTH);

    // Health value as it will be stored in the shadow register.
    always_comb begin
        health_in = wdata[HEALTH_W+1:2];
`ifdef T03_DPU_HEALTH_CLAMP_EN
        if (32'(wdata[HEALTH_W+1:2]) > 32'(MAX_HEALTH)) begin
            health_in = HEALTH_W'(MAX_HEALTH);
        end
`endif
    end

    // Shadow registers: CPU writes land here.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_state  <= STAND;
            shd_health <= '0;
            shd_x      <= '0;
            shd_y      <= '0;
        end else begin
            if (stat_we) begin
                shd_state  <= player_state_t'(wdata[1:0]);
                shd_health <= health_in;
            end
            if (pos_we) begin
                shd_x <= wdata[16 +: COORD_W];
                shd_y <= wdata[0 +: COORD_W];
            end
        end
    end

    // Active registers: take the pre-write shadow at a frame commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_state  <= STAND;
            act_health <= '0;
            act_x      <= '0;
            act_y      <= '0;
        end else if (commit_en) begin
            act_state  <= shd_state;
            act_health <= shd_health;
            act_x      <= shd_x;
            act_y      <= shd_y;
        end
    end

    assign state       = act_state;
    assign health      = act_health;
    assign x           = act_x;
    assign y           = act_y;
    assign stat_word_c = 32'({shd_health, shd_state});
    assign pos_word_c  = {16'(shd_x), 16'(shd_y)};

endmodule

// File: rtl/t03_dpu_mmio_regs.sv
// MMIO register bank feeding the DPU: shadow bank written by the CPU,
// copied to the active bank on vsync, registered readback of the shadow.
// Optional build macro: T03_DPU_HEALTH_CLAMP_EN (health clamped to MAX_HEALTH).
module t03_dpu_mmio_regs
    import t03_dpu_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned HEALTH_W    = 5,
    parameter int unsigned MAX_HEALTH  = 31,
    parameter logic [31:0] BASE_ADDR   = 32'hFF000003
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic [31:0]                     addr,
    input  logic [31:0]                     wdata,
    output logic [31:0]                     rdata,
    output logic                            rd_valid,
    input  logic                            vsync,
    output logic [1:0]                      game_state,
    output logic [2*NUM_PLAYERS-1:0]        p_state,
    output logic [HEALTH_W*NUM_PLAYERS-1:0] p_health,
    output logic [COORD_W*NUM_PLAYERS-1:0]  p_x,
    output logic [COORD_W*NUM_PLAYERS-1:0]  p_y,
    output logic                            pending,
    output logic                            commit
);

    localparam int unsigned LAST_OFF = 2 * NUM_PLAYERS;

    logic [31:0]  offset;
    logic         mapped;
    logic         wr_hit;
    logic         commit_now;
    logic [31:0]  rd_word;
    logic [31:0]  stat_words [NUM_PLAYERS];
    logic [31:0]  pos_words  [NUM_PLAYERS];
    game_state_t  shd_game, act_game;

    assign offset     = addr - BASE_ADDR;
    assign mapped     = (offset <= 32'(LAST_OFF));
    assign wr_hit     = wr_en & mapped;
    assign commit_now = vsync & pending;

    // Game word shadow and active copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_game <= IDLE;
            act_game <= IDLE;
        end else begin
            if (commit_now) begin
                act_game <= shd_game;
            end
            if (wr_en && (offset == 32'(OFF_GAME))) begin
                shd_game <= game_state_t'(wdata[1:0]);
            end
        end
    end

    // Dirty tracking and commit pulse; a write racing a commit stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            commit  <= 1'b0;
        end else begin
            pending <= (pending & ~commit_now) | wr_hit;
            commit  <= commit_now;
        end
    end

    // Per-player register slices.
    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
        t03_dpu_player_regs #(
            .COORD_W    (COORD_W),
            .HEALTH_W   (HEALTH_W),
            .MAX_HEALTH (MAX_HEALTH)
        ) u_player (
            .clk         (clk),
            .rst         (rst),
            .stat_we     (wr_en && (offset == stat_off(i))),
            .pos_we      (wr_en && (offset == pos_off(i))),
            .wdata       (wdata),
            .commit_en   (commit_now),
            .state       (p_state[2*i +: 2]),
            .health      (p_health[HEALTH_W*i +: HEALTH_W]),
            .x           (p_x[COORD_W*i +: COORD_W]),
            .y           (p_y[COORD_W*i +: COORD_W]),
            .stat_word_c (stat_words[i]),
            .pos_word_c  (pos_words[i])
        );
    end

    // Readback mux over the shadow bank; unmapped offsets read as zero.
    always_comb begin
        rd_word = '0;
        if (offset == 32'(OFF_GAME)) begin
            rd_word = 32'(shd_game);
        end
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (offset == stat_off(i)) begin
                rd_word = stat_words[i];
            end
            if (offset == pos_off(i)) begin
                rd_word = pos_words[i];
            end
        end
    end

    // One-cycle registered read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rdata    <= rd_en ? rd_word : '0;
            rd_valid <= rd_en;
        end
    end

    assign game_state = act_game;

endmodule

// File: tb/tb_t03_dpu_mmio_regs.sv
// Bench for t03_dpu_mmio_regs: directed vector table, random traffic against
// a behavioural register-bank model, and a reset-while-pending sequence.
module tb_t03_dpu_mmio_regs;

    localparam int unsigned NP   = 2;
    localparam int unsigned CW   = 11;
    localparam int unsigned HW   = 5;
    localparam int unsigned MAXH = 31;
    localparam logic [31:0] BASE = 32'hFF000003;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_en = 1'b0;
    logic                 rd_en = 1'b0;
    logic                 vsync = 1'b0;
    logic [31:0]          addr = BASE;
    logic [31:0]          wdata = '0;
    logic [31:0]          rdata;
    logic                 rd_valid;
    logic [1:0]           game_state;
    logic [2*NP-1:0]      p_state;
    logic [HW*NP-1:0]     p_health;
    logic [CW*NP-1:0]     p_x, p_y;
    logic                 pending, commit;

    int checks = 0;
    int errors = 0;

    t03_dpu_mmio_regs #(
        .NUM_PLAYERS (NP),
        .COORD_W     (CW),
        .HEALTH_W    (HW),
        .MAX_HEALTH  (MAXH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rd_valid   (rd_valid),
        .vsync      (vsync),
        .game_state (game_state),
        .p_state    (p_state),
        .p_health   (p_health),
        .p_x        (p_x),
        .p_y        (p_y),
        .pending    (pending),
        .commit     (commit)
    );

    always #5 clk = ~clk;

    // Reference model: shadow and active banks as plain arrays.
    logic [31:0] m_game_s, m_game_a;
    logic [31:0] m_st_s [NP], m_hp_s [NP], m_x_s [NP], m_y_s [NP];
    logic [31:0] m_st_a [NP], m_hp_a [NP], m_x_a [NP], m_y_a [NP];
    bit          m_pend, m_commit, m_rdv;
    logic [31:0] m_rdata;

    task automatic model_reset();
        m_game_s = 0; m_game_a = 0;
        for (int p = 0; p < NP; p++) begin
            m_st_s[p] = 0; m_hp_s[p] = 0; m_x_s[p] = 0; m_y_s[p] = 0;
            m_st_a[p] = 0; m_hp_a[p] = 0; m_x_a[p] = 0; m_y_a[p] = 0;
        end
        m_pend = 0; m_commit = 0; m_rdv = 0; m_rdata = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] off);
        int p;
        if (off == 0) return m_game_s;
        if (off <= 2 * NP) begin
            p = int'((off - 1) / 2);
            if (off % 2 == 1) return (m_hp_s[p] << 2) | m_st_s[p];
            return (m_x_s[p] << 16) | m_y_s[p];
        end
        return 0;
    endfunction

    task automatic model_step(input bit we, input bit re, input bit vs,
                              input logic [31:0] off, input logic [31:0] wd);
        bit mapped;
        int p;
        logic [31:0] h;
        mapped   = (off <= 2 * NP);
        m_rdv    = re;
        m_rdata  = re ? model_read(off) : 0;
        m_commit = vs && m_pend;
        if (m_commit) begin
            m_game_a = m_game_s;
            for (int q = 0; q < NP; q++) begin
                m_st_a[q] = m_st_s[q]; m_hp_a[q] = m_hp_s[q];
                m_x_a[q]  = m_x_s[q];  m_y_a[q]  = m_y_s[q];
            end
        end
        if (we && mapped) begin
            if (off == 0) begin
                m_game_s = wd % 4;
            end else begin
                p = int'((off - 1) / 2);
                if (off % 2 == 1) begin
                    h = (wd >> 2) % (1 << HW);
`ifdef T03_DPU_HEALTH_CLAMP_EN
                    if (h > MAXH) h = MAXH;
`endif
                    m_hp_s[p] = h;
                    m_st_s[p] = wd % 4;
                end else begin
                    m_x_s[p] = (wd >> 16) % (1 << CW);
                    m_y_s[p] = wd % (1 << CW);
                end
            end
        end
        m_pend = (m_pend && !m_commit) || (we && mapped);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] es, eh, ex, ey;
        es = 0; eh = 0; ex = 0; ey = 0;
        for (int p = 0; p < NP; p++) begin
            es |= 64'(m_st_a[p]) << (2 * p);
            eh |= 64'(m_hp_a[p]) << (HW * p);
            ex |= 64'(m_x_a[p]) << (CW * p);
            ey |= 64'(m_y_a[p]) << (CW * p);
        end
        chk({tag, ".game"}, 64'(game_state), 64'(m_game_a));
        chk({tag, ".p_state"}, 64'(p_state), es);
        chk({tag, ".p_health"}, 64'(p_health), eh);
        chk({tag, ".p_x"}, 64'(p_x), ex);
        chk({tag, ".p_y"}, 64'(p_y), ey);
        chk({tag, ".pending"}, 64'(pending), 64'(m_pend));
        chk({tag, ".commit"}, 64'(commit), 64'(m_commit));
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_rdv));
        if (m_rdv) chk({tag, ".rdata"}, 64'(rdata), 64'(m_rdata));
    endtask

    // One bus cycle: drive, clock, advance the model, sample after the edge.
    task automatic cyc(input bit we, input bit re, input bit vs,
                       input logic [31:0] off, input logic [31:0] wd);
        wr_en = we; rd_en = re; vsync = vs;
        addr  = BASE + off; wdata = wd;
        @(posedge clk);
        #1;
        model_step(we, re, vs, off, wd);
    endtask

    typedef struct {
        bit          we, re, vs;
        logic [31:0] off, wd;
        bit          e_pend, e_com, e_rdv;
        logic [31:0] e_rdata;
        logic [1:0]  e_game;
        logic [4:0]  e_h0;
        logic [1:0]  e_s0;
        logic [10:0] e_x0, e_y0;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // we re vs off wd | pend com rdv rdata | game h0 s0 x0 y0
        tbl[0]  = '{1, 0, 0, 1, 32'h0000_0079, 1, 0, 0, 0,            0, 0,  0, 0,     0};
        tbl[1]  = '{0, 0, 1, 0, 0,             0, 1, 0, 0,            0, 30, 1, 0,     0};
        tbl[2]  = '{0, 0, 0, 0, 0,             0, 0, 0, 0,            0, 30, 1, 0,     0};
        tbl[3]  = '{1, 0, 0, 2, 32'h0123_0045, 1, 0, 0, 0,            0, 30, 1, 0,     0};
        tbl[4]  = '{0, 0, 1, 0, 0,             0, 1, 0, 0,            0, 30, 1, 'h123, 'h045};
        tbl[5]  = '{1, 0, 0, 2, 32'hFFFF_FFFF, 1, 0, 0, 0,            0, 30, 1, 'h123, 'h045};
        tbl[6]  = '{0, 0, 1, 0, 0,             0, 1, 0, 0,            0, 30, 1, 'h7FF, 'h7FF};
        tbl[7]  = '{1, 0, 0, 0, 1,             1, 0, 0, 0,            0, 30, 1, 'h7FF, 'h7FF};
        tbl[8]  = '{1, 0, 1, 0, 2,             1, 1, 0, 0,            1, 30, 1, 'h7FF, 'h7FF};
        tbl[9]  = '{0, 0, 1, 0, 0,             0, 1, 0, 0,            2, 30, 1, 'h7FF, 'h7FF};
        tbl[10] = '{1, 0, 0, 4, 32'h00C8_0064, 1, 0, 0, 0,            2, 30, 1, 'h7FF, 'h7FF};
        tbl[11] = '{0, 1, 0, 4, 0,             1, 0, 1, 32'h00C8_0064, 2, 30, 1, 'h7FF, 'h7FF};
        tbl[12] = '{1, 1, 0, 9, 32'hDEAD_BEEF, 1, 0, 1, 0,            2, 30, 1, 'h7FF, 'h7FF};
        tbl[13] = '{0, 0, 1, 0, 0,             0, 1, 0, 0,            2, 30, 1, 'h7FF, 'h7FF};
        tbl[14] = '{1, 1, 0, 1, 32'h0000_0002, 1, 0, 1, 32'h0000_0079, 2, 30, 1, 'h7FF, 'h7FF};
        tbl[15] = '{0, 1, 0, 1, 0,             1, 0, 1, 32'h0000_0002, 2, 30, 1, 'h7FF, 'h7FF};

        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_model("reset");

        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0);
            check_model("idle");
        end

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].we, tbl[i].re, tbl[i].vs, tbl[i].off, tbl[i].wd);
            chk($sformatf("vec%0d.pending", i), 64'(pending), 64'(tbl[i].e_pend));
            chk($sformatf("vec%0d.commit", i), 64'(commit), 64'(tbl[i].e_com));
            chk($sformatf("vec%0d.rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rdv));
            if (tbl[i].e_rdv) chk($sformatf("vec%0d.rdata", i), 64'(rdata), 64'(tbl[i].e_rdata));
            chk($sformatf("vec%0d.game", i), 64'(game_state), 64'(tbl[i].e_game));
            chk($sformatf("vec%0d.h0", i), 64'(p_health[HW-1:0]), 64'(tbl[i].e_h0));
            chk($sformatf("vec%0d.s0", i), 64'(p_state[1:0]), 64'(tbl[i].e_s0));
            chk($sformatf("vec%0d.x0", i), 64'(p_x[CW-1:0]), 64'(tbl[i].e_x0));
            chk($sformatf("vec%0d.y0", i), 64'(p_y[CW-1:0]), 64'(tbl[i].e_y0));
        end

        // Random traffic; mostly mapped offsets, some just past the map, some far away.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] off;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      off = 32'($urandom_range(0, 2 * NP));
            else if (sel < 9) off = 32'($urandom_range(2 * NP + 1, 2 * NP + 3));
            else              off = $urandom();
            cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0), off, $urandom());
            check_model("rand");
        end

        // Reset while a commit is pending discards it; following vsync is a no-op.
        cyc(1, 0, 0, 3, 32'h0000_0055);
        chk("rstseq.pending_before", 64'(pending), 64'd1);
        rst = 1'b1; vsync = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_model("rstseq.after_rst");
        cyc(0, 0, 1, 0, 0);
        chk("rstseq.no_commit", 64'(commit), 64'd0);
        chk("rstseq.pending_after", 64'(pending), 64'd0);
        check_model("rstseq.vsync");
        cyc(0, 1, 0, 3, 0);
        chk("rstseq.readback", 64'(rdata), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
